// File: rtl/mem_if_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_param
// Purpose  : Single-port memory slave with valid/ready request channel,
//            fixed or LFSR-driven acceptance delay and a registered,
//            back-pressurable read-response channel.
// Revision : 1.0 - initial release
// ============================================================================
module mem_if_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int LAT_W    = 4,
    parameter int RAND_LAT = 1,
    parameter int FIX_LAT  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid_i,
    input  logic                req_rnw_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                req_ready_o,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    input  logic                rsp_ready_i
);

    localparam int              c_BE_W    = DATA_W / 8;
    localparam int              c_DEPTH   = 2 ** ADDR_W;
    localparam logic [LAT_W-1:0] c_FIX_CNT = LAT_W'(FIX_LAT);
    localparam logic [7:0]      c_LFSR_SEED = 8'hE1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [LAT_W-1:0]  r_cnt;
    logic [7:0]        r_lfsr;
    logic              r_rnw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [c_BE_W-1:0] r_be;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [LAT_W-1:0]  w_load_cnt;
    logic              w_commit;
    logic              w_lfsr_fb;

    generate
        if (RAND_LAT != 0) begin : g_rand_lat
            if (LAT_W <= 8) begin : g_narrow
                assign w_load_cnt = r_lfsr[LAT_W-1:0];
            end else begin : g_wide
                assign w_load_cnt = {{(LAT_W-8){1'b0}}, r_lfsr};
            end
        end else begin : g_fix_lat
            assign w_load_cnt = c_FIX_CNT;
        end
    endgenerate

    // The access happens on the same edge that ends the req_ready_o pulse.
    assign w_commit  = (r_state == c_WAIT) && (r_cnt == '0);
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign req_ready_o = w_commit;
    assign rsp_valid_o = (r_state == c_RESP);
    assign rsp_rdata_o = rsp_valid_o ? r_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_lfsr  <= c_LFSR_SEED;
            r_rnw   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            case (r_state)
                c_IDLE: begin
                    if (req_valid_i) begin
                        r_rnw   <= req_rnw_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_be    <= req_be_i;
                        r_cnt   <= w_load_cnt;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_rnw) begin
                        r_rdata <= r_mem[r_addr];
                        r_state <= c_RESP;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && !r_rnw) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (r_be[b]) begin
                    r_mem[r_addr][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_if_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_if_param
// Purpose  : Scoreboard bench for mem_if_param; three instances cover fixed
//            delay 3, LFSR delay and fixed delay 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_if_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [3];
    logic        req_rnw   [3];
    logic [3:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_ready [3];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mem_if_param #(
                .DATA_W  (32),
                .ADDR_W  (4),
                .LAT_W   (4),
                .RAND_LAT((g == 1) ? 1 : 0),
                .FIX_LAT ((g == 0) ? 3 : 0)
            ) u_dut (
                .clk        (clk),
                .reset      (reset),
                .req_valid_i(req_valid[g]),
                .req_rnw_i  (req_rnw[g]),
                .req_addr_i (req_addr[g]),
                .req_wdata_i(req_wdata[g]),
                .req_be_i   (req_be[g]),
                .req_ready_o(req_ready[g]),
                .rsp_valid_o(rsp_valid[g]),
                .rsp_rdata_o(rsp_rdata[g]),
                .rsp_ready_i(rsp_ready[g])
            );
        end
    endgenerate

    typedef struct { int idx; int cyc; } rdy_t;
    typedef struct { int idx; int cyc; logic [31:0] data; } rsp_t;

    rdy_t        rdy_q [$];
    rsp_t        rsp_q [$];
    bit          rsp_seen;
    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [7:0]  m_lfsr;
    logic [31:0] mm [3][16];

    task automatic check(input string name, input bit ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed E1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) m_lfsr <= 8'hE1;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int g = 0; g < 3; g++) begin
                if (req_ready[g]) begin
                    if (rdy_q.size() == 0) begin
                        check("unexpected_ready", 1'b0, 64'(g), 64'hFFFF);
                    end else begin
                        rdy_t e;
                        e = rdy_q.pop_front();
                        check("ready_cycle", e.idx == g && e.cyc == cyc, 64'(cyc), 64'(e.cyc));
                    end
                end
                if (rsp_valid[g]) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_rsp", 1'b0, 64'(g), 64'hFFFF);
                    end else begin
                        if (!rsp_seen) begin
                            check("rsp_valid_cycle", rsp_q[0].idx == g && rsp_q[0].cyc == cyc,
                                  64'(cyc), 64'(rsp_q[0].cyc));
                            rsp_seen = 1'b1;
                        end
                        check("rsp_data", rsp_rdata[g] == rsp_q[0].data,
                              64'(rsp_rdata[g]), 64'(rsp_q[0].data));
                        if (rsp_ready[g]) begin
                            void'(rsp_q.pop_front());
                            rsp_seen = 1'b0;
                        end
                    end
                end else begin
                    check("rdata_idle_zero", rsp_rdata[g] == 32'h0, 64'(rsp_rdata[g]), 64'h0);
                end
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic wait_ready(input int g);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (req_ready[g]) got = 1'b1;
        end
        if (!got) check("ready_timeout", 1'b0, 64'h0, 64'h1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int g);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[g] && rsp_ready[g]) got = 1'b1;
        end
        if (!got) check("rsp_timeout", 1'b0, 64'h0, 64'h1);
        @(posedge clk); #1;
    endtask

    // Drives one request while the instance is idle and queues its expectations.
    task automatic drive(input int g, input bit rnw, input logic [3:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        rdy_t e;
        rsp_t r;
        int   d;
        d = (g == 1) ? int'(m_lfsr[3:0]) : ((g == 0) ? 3 : 0);
        req_valid[g] = 1'b1;
        req_rnw[g]   = rnw;
        req_addr[g]  = a;
        req_wdata[g] = wd;
        req_be[g]    = be;
        e.idx = g;
        e.cyc = cyc + 1 + d;
        rdy_q.push_back(e);
        if (rnw) begin
            r.idx  = g;
            r.cyc  = cyc + 2 + d;
            r.data = mm[g][a];
            rsp_q.push_back(r);
        end else begin
            mm[g][a] = merge(mm[g][a], wd, be);
        end
    endtask

    task automatic do_req(input int g, input bit rnw, input logic [3:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        drive(g, rnw, a, wd, be);
        wait_ready(g);
        req_valid[g] = 1'b0;
        req_wdata[g] = ~wd;
        if (rnw) wait_rsp(g);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rdy_t e;
        cyc = 0; n_checks = 0; n_pass = 0; rsp_seen = 1'b0;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0; req_rnw[g] = 1'b0; req_addr[g] = '0;
            req_wdata[g] = '0;   req_be[g]  = '0;   rsp_ready[g] = 1'b1;
            for (int a = 0; a < 16; a++) mm[g][a] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("reset_ready", req_ready[g] == 1'b0, 64'(req_ready[g]), 64'h0);
            check("reset_valid", rsp_valid[g] == 1'b0, 64'(rsp_valid[g]), 64'h0);
            check("reset_rdata", rsp_rdata[g] == 32'h0, 64'(rsp_rdata[g]), 64'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Fixed delay 3: write then read, then byte-masked merge.
        do_req(0, 1'b0, 4'd5, 32'hDEADBEEF, 4'hF);
        do_req(0, 1'b1, 4'd5, 32'h0, 4'h0);
        do_req(0, 1'b0, 4'd5, 32'h00001234, 4'b0011);
        do_req(0, 1'b1, 4'd5, 32'h0, 4'h0);
        do_req(0, 1'b0, 4'd5, 32'hFFFFFFFF, 4'h0);
        do_req(0, 1'b1, 4'd5, 32'h0, 4'h0);
        check("byte_merge_model", mm[0][5] == 32'hDEAD1234, 64'(mm[0][5]), 64'hDEAD1234);

        // Zero delay: back-to-back writes over the full address range, then readback.
        for (int a = 0; a < 16; a++) do_req(2, 1'b0, 4'(a), {8'hA5, 8'(a), 16'h5A5A}, 4'hF);
        for (int a = 0; a < 16; a++) do_req(2, 1'b1, 4'(a), 32'h0, 4'h0);
        do_req(2, 1'b1, 4'd15, 32'h0, 4'h0);
        do_req(2, 1'b1, 4'd0, 32'h0, 4'h0);

        // Backpressure: stall the response 5 cycles while a write is held pending.
        rsp_ready[2] = 1'b0;
        drive(2, 1'b1, 4'd7, 32'h0, 4'h0);
        wait_ready(2);
        drive(2, 1'b0, 4'd8, 32'h0BADCAFE, 4'hF);
        void'(rdy_q.pop_back());
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", rsp_valid[2] == 1'b1, 64'(rsp_valid[2]), 64'h1);
            @(posedge clk); #1;
        end
        rsp_ready[2] = 1'b1;
        e.idx = 2;
        e.cyc = cyc + 2;
        rdy_q.push_back(e);
        wait_ready(2);
        req_valid[2] = 1'b0;
        do_req(2, 1'b1, 4'd8, 32'h0, 4'h0);

        // LFSR-driven delay: initialise all words, then random traffic.
        for (int a = 0; a < 16; a++) do_req(1, 1'b0, 4'(a), 32'h1000_0000 + 32'(a), 4'hF);
        for (int i = 0; i < 200; i++) begin
            do_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during the wait phase of a write must abandon it.
        do_req(0, 1'b0, 4'd2, 32'h0, 4'hF);
        req_valid[0] = 1'b1; req_rnw[0] = 1'b0; req_addr[0] = 4'd2;
        req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", req_ready[0] == 1'b0, 64'(req_ready[0]), 64'h0);
        check("rst_mid_valid", rsp_valid[0] == 1'b0, 64'(rsp_valid[0]), 64'h0);
        check("rst_mid_rdata", rsp_rdata[0] == 32'h0, 64'(rsp_rdata[0]), 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(0, 1'b1, 4'd2, 32'h0, 4'h0);

        repeat (5) @(posedge clk);
        #1;
        check("ready_queue_empty", rdy_q.size() == 0, 64'(rdy_q.size()), 64'h0);
        check("rsp_queue_empty", rsp_q.size() == 0, 64'(rsp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
